execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Y86-64 pipelined execute stage: consumes decoded operands (valA/valB/valC, dstE/dstM),
//  runs the ALU, owns the condition-code register and evaluates Cnd for cmovXX/jXX.
//  Output is registered into the E->M pipeline register. e_valE/e_dstE are combinational
//  forwarding taps back to decode. Sits directly downstream of decode, upstream of memory.
// PARAMETERS
//  W      64   datapath width (valA/valB/valC/valE)
//  RNONE  4'hF register id meaning "no register"
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  E_stat       in   3   stat of instruction in E (1 AOK, 2 HLT, 3 ADR, 4 INS)
//  E_icode      in   4   icode: 0 halt,1 nop,2 rrmov/cmov,3 irmov,4 rmmov,5 mrmov,6 OPq,7 jXX,8 call,9 ret,A push,B pop
//  E_ifun       in   4   function code (ALU op or condition)
//  E_valC       in   W   constant word
//  E_valA       in   W   operand A from decode
//  E_valB       in   W   operand B from decode
//  E_dstE       in   4   E-port destination register
//  E_dstM       in   4   M-port destination register
//  cc_block     in   1   later stage holds exception (m_stat or W_stat not AOK): inhibit CC update
//  M_stall      in   1   hold the M pipeline register
//  M_bubble     in   1   load a bubble into the M pipeline register
//  e_Cnd        out  1   combinational condition result
//  e_valE       out  W   combinational ALU result (forwarding tap)
//  e_dstE       out  4   combinational effective dstE (forwarding tap)
//  M_stat/M_icode/M_Cnd/M_valE/M_valA/M_dstE/M_dstM  out 3/4/1/W/W/4/4  registered E->M outputs
// BEHAVIOUR
//  aluA: icode 2,6->valA; 3,4,5->valC; 8,A->-8; 9,B->+8; else 0.
//  aluB: icode 4,5,6,8,9,A,B->valB; 2,3->0; else 0.
//  alufun = (icode==6) ? ifun[1:0] : ADD. 0 ADD aluB+aluA; 1 SUB aluB-aluA; 2 AND; 3 XOR. Mod 2^W.
//  icode 6 with ifun>3: result 0, CC still updated from that result (stat already INS upstream).
//  CC {ZF,SF,OF}: reset {1,0,0}. Updated at posedge iff icode==6 && E_stat==AOK && !cc_block.
//   ZF=(res==0); SF=res[W-1]; OF: ADD (a[W-1]==b[W-1])&&(res[W-1]!=a[W-1]);
//   SUB (b[W-1]!=a[W-1])&&(res[W-1]!=b[W-1]); AND/XOR OF=0.
//  e_Cnd from current CC (pre-update value, combinational), ifun:
//   0 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7..F 0.
//  e_dstE = (icode==2 && !e_Cnd) ? RNONE : E_dstE.
//  M register: M_bubble -> bubble; else M_stall -> hold; else load {E_stat,E_icode,e_Cnd,e_valE,E_valA,e_dstE,E_dstM}.
//   M_bubble wins over M_stall when both high. Latency: E inputs visible at M outputs 1 cycle later.
//  Bubble / reset value: stat=AOK, icode=1 (nop), Cnd=0, valE=0, valA=0, dstE=dstM=RNONE.
//  rst_n low mid-operation: CC and M register clear immediately (async), held until rst_n high.
//  CC update and M load at same edge are independent; M_stall does not block CC update.
// CONFIGURATION
//  EXEC_PERF_CNT_EN defined: adds outputs perf_opq_cnt[31:0] and perf_jtaken_cnt[31:0].
//   perf_opq_cnt +1 on each edge where CC updates; perf_jtaken_cnt +1 on each edge
//   with icode==7, E_stat==AOK, e_Cnd==1, !M_stall, !M_bubble. Both wrap modulo 2^32, reset 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset: rst_n=0 -> M_icode=1, M_dstE=M_dstM=F, M_valE=0, CC={ZF1,SF0,OF0}; jXX ifun=3 -> e_Cnd=1.
//  OPq sub valA=5 valB=5 -> M_valE=0 next cycle, ZF=1; then jne -> e_Cnd=0, je -> e_Cnd=1.
//  OPq add valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, SF=1, OF=1, ZF=0.
//  OPq with cc_block=1 -> CC unchanged; cmovl (ifun 2) with SF^OF=0 -> e_dstE=F, M_dstE=F.
//  push icode A valB=0x100 -> M_valE=0xF8, M_dstE=4; M_stall=1 holds it; M_stall+M_bubble -> nop bubble.
//  EXEC_PERF_CNT_EN: 3 OPq + 2 taken jmp (ifun 0) -> perf_opq_cnt=3, perf_jtaken_cnt=2; preload 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/execute_if.sv
// execute_if: decode->execute operand bundle plus execute forwarding taps and E->M register outputs.
interface execute_if #(parameter int W = 64);
  logic [2:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valC;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic         cc_block;
  logic         M_stall;
  logic         M_bubble;
  logic         e_Cnd;
  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;
  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, cc_block, M_stall, M_bubble,
    input  e_Cnd, e_valE, e_dstE, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, cc_block, M_stall, M_bubble,
    output e_Cnd, e_valE, e_dstE, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage (ALU, condition codes, Cnd, E->M register).
// Optional EXEC_PERF_CNT_EN adds OPq and taken-jump event counters.
module execute_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic clk,
    input logic rst_n,
    execute_if.slave bus
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0] perf_opq_cnt,
    output logic [31:0] perf_jtaken_cnt
`endif
);
    localparam logic [2:0] AOK = 3'd1;
    typedef struct packed {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] vale;
        logic [W-1:0] vala;
        logic [3:0]   dste;
        logic [3:0]   dstm;
    } m_t;
    localparam m_t NOP = '{stat: AOK, icode: 4'h1, cnd: 1'b0, vale: '0, vala: '0, dste: RNONE, dstm: RNONE};
    logic [W-1:0] alu_a, alu_b, res;
    logic [1:0]   fn;
    logic         bad_op, zf_q, sf_q, of_q, zf_d, sf_d, of_d, cc_en, cnd;
    m_t           m_q, m_d;
    always_comb begin
        alu_a = '0;
        case (bus.E_icode)
            4'h2, 4'h6:       alu_a = bus.E_valA;
            4'h3, 4'h4, 4'h5: alu_a = bus.E_valC;
            4'h8, 4'hA:       alu_a = -(W'(8));
            4'h9, 4'hB:       alu_a = W'(8);
            default:          alu_a = '0;
        endcase
    end
    assign alu_b  = (bus.E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? bus.E_valB : '0;
    assign fn     = (bus.E_icode == 4'h6) ? bus.E_ifun[1:0] : 2'd0;
    assign bad_op = (bus.E_icode == 4'h6) && (bus.E_ifun[3:2] != 2'b00);
    assign res    = bad_op ? '0 : fn == 2'd0 ? alu_b + alu_a : fn == 2'd1 ? alu_b - alu_a :
                    fn == 2'd2 ? alu_b & alu_a : alu_b ^ alu_a;
    assign zf_d   = (res == '0);
    assign sf_d   = res[W-1];
    assign of_d   = bad_op ? 1'b0 :
                    fn == 2'd0 ? (alu_a[W-1] == alu_b[W-1]) && (res[W-1] != alu_a[W-1]) :
                    fn == 2'd1 ? (alu_b[W-1] != alu_a[W-1]) && (res[W-1] != alu_b[W-1]) : 1'b0;
    assign cc_en  = (bus.E_icode == 4'h6) && (bus.E_stat == AOK) && !bus.cc_block;
    // Cnd always reflects the flags as they stand before this cycle's update
    always_comb begin
        case (bus.E_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf_q ^ of_q) | zf_q;
            4'd2:    cnd = sf_q ^ of_q;
            4'd3:    cnd = zf_q;
            4'd4:    cnd = !zf_q;
            4'd5:    cnd = !(sf_q ^ of_q);
            4'd6:    cnd = !(sf_q ^ of_q) && !zf_q;
            default: cnd = 1'b0;
        endcase
    end
    assign bus.e_Cnd  = cnd;
    assign bus.e_valE = res;
    assign bus.e_dstE = (bus.E_icode == 4'h2 && !cnd) ? RNONE : bus.E_dstE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {zf_q, sf_q, of_q} <= 3'b100;
        end else if (cc_en) begin
            {zf_q, sf_q, of_q} <= {zf_d, sf_d, of_d};
        end
    end
    assign m_d = bus.M_bubble ? NOP : bus.M_stall ? m_q :
                 '{stat: bus.E_stat, icode: bus.E_icode, cnd: cnd, vale: res, vala: bus.E_valA,
                   dste: bus.e_dstE, dstm: bus.E_dstM};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_q <= NOP;
        else m_q <= m_d;
    end
    assign bus.M_stat  = m_q.stat;
    assign bus.M_icode = m_q.icode;
    assign bus.M_Cnd   = m_q.cnd;
    assign bus.M_valE  = m_q.vale;
    assign bus.M_valA  = m_q.vala;
    assign bus.M_dstE  = m_q.dste;
    assign bus.M_dstM  = m_q.dstm;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] opq_q, jt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opq_q <= '0;
            jt_q  <= '0;
        end else begin
            opq_q <= opq_q + 32'(cc_en);
            jt_q  <= jt_q + 32'(bus.E_icode == 4'h7 && bus.E_stat == AOK && cnd && !bus.M_stall && !bus.M_bubble);
        end
    end
    assign perf_opq_cnt    = opq_q;
    assign perf_jtaken_cnt = jt_q;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: random + directed stimulus against a flag/arithmetic reference model with an M-register scoreboard.
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    execute_if #(.W(64)) bus ();
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_opq_cnt, perf_jtaken_cnt;
`endif
    execute_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef EXEC_PERF_CNT_EN
        ,
        .perf_opq_cnt(perf_opq_cnt),
        .perf_jtaken_cnt(perf_jtaken_cnt)
`endif
    );
    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        int unsigned opq;
        int unsigned jt;
    } exp_t;
    exp_t q[$];
    exp_t m_exp;
    bit zf, sf, of;
    int unsigned opq, jt;
    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t nop_m();
        exp_t n;
        n = '{stat: 3'd1, icode: 4'h1, cnd: 1'b0, vale: 64'd0, vala: 64'd0, dste: 4'hF, dstm: 4'hF, opq: opq, jt: jt};
        return n;
    endfunction

    task automatic model_reset();
        {zf, sf, of} = 3'b100;
        opq = 0;
        jt = 0;
        m_exp = nop_m();
    endtask

    function automatic logic cond(logic [3:0] f);
        case (f)
            4'd0: return 1'b1;
            4'd1: return (sf != of) || zf;
            4'd2: return sf != of;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return sf == of;
            4'd6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(int stat, int icode, int ifun, logic [63:0] c, logic [63:0] a, logic [63:0] b,
                         int de, int dm, bit ccb, bit stall, bit bub);
        bus.E_stat = 3'(stat);
        bus.E_icode = 4'(icode);
        bus.E_ifun = 4'(ifun);
        bus.E_valC = c;
        bus.E_valA = a;
        bus.E_valB = b;
        bus.E_dstE = 4'(de);
        bus.E_dstM = 4'(dm);
        bus.cc_block = ccb;
        bus.M_stall = stall;
        bus.M_bubble = bub;
    endtask

    // One cycle: check combinational taps against the model, cross the edge, queue the expected M contents.
    task automatic step();
        logic [63:0] a, b, val;
        logic [64:0] wide;
        logic c;
        logic [3:0] de;
        bit upd, nz, ns, no;
        exp_t nxt;
        int ic;
        ic = int'(bus.E_icode);
        a = (ic == 2 || ic == 6) ? bus.E_valA : (ic >= 3 && ic <= 5) ? bus.E_valC :
            (ic == 8 || ic == 10) ? 64'hFFFF_FFFF_FFFF_FFF8 : (ic == 9 || ic == 11) ? 64'd8 : 64'd0;
        b = (ic >= 4 && ic <= 11 && ic != 7) ? bus.E_valB : 64'd0;
        no = 0;
        if (ic != 6 || bus.E_ifun == 0) begin
            wide = {b[63], b} + {a[63], a};
            no = wide[64] != wide[63];
            val = wide[63:0];
        end else if (bus.E_ifun == 1) begin
            wide = {b[63], b} - {a[63], a};
            no = wide[64] != wide[63];
            val = wide[63:0];
        end else if (bus.E_ifun == 2) val = a & b;
        else if (bus.E_ifun == 3) val = a ^ b;
        else val = 64'd0;
        if (ic == 6 && bus.E_ifun > 3) no = 0;
        nz = (val == 0);
        ns = val[63];
        c = cond(bus.E_ifun);
        de = (ic == 2 && !c) ? 4'hF : bus.E_dstE;
        upd = (ic == 6) && (bus.E_stat == 3'd1) && !bus.cc_block;
        #1;
        chk("e_valE", bus.e_valE, val);
        chk("e_Cnd", bus.e_Cnd, c);
        chk("e_dstE", bus.e_dstE, de);
        nxt = '{stat: bus.E_stat, icode: bus.E_icode, cnd: c, vale: val, vala: bus.E_valA, dste: de,
                dstm: bus.E_dstM, opq: 0, jt: 0};
        @(posedge clk);
        if (ic == 7 && bus.E_stat == 3'd1 && c && !bus.M_stall && !bus.M_bubble) jt++;
        if (upd) begin
            {zf, sf, of} = {nz, ns, no};
            opq++;
        end
        if (bus.M_bubble) m_exp = nop_m();
        else if (!bus.M_stall) m_exp = nxt;
        m_exp.opq = opq;
        m_exp.jt = jt;
        q.push_back(m_exp);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("M_stat", bus.M_stat, e.stat);
            chk("M_icode", bus.M_icode, e.icode);
            chk("M_Cnd", bus.M_Cnd, e.cnd);
            chk("M_valE", bus.M_valE, e.vale);
            chk("M_valA", bus.M_valA, e.vala);
            chk("M_dstE", bus.M_dstE, e.dste);
            chk("M_dstM", bus.M_dstM, e.dstm);
`ifdef EXEC_PERF_CNT_EN
            chk("perf_opq_cnt", perf_opq_cnt, 64'(e.opq));
            chk("perf_jtaken_cnt", perf_jtaken_cnt, 64'(e.jt));
`endif
        end
    end

    function automatic logic [63:0] rnd64();
        case ($urandom_range(4))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(16));
            2: return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(2));
            3: return 64'h8000_0000_0000_0000 + 64'($urandom_range(2));
            default: return -64'($urandom_range(3));
        endcase
    endfunction

    initial begin
        int ic;
        model_reset();
        drive(1, 7, 3, 0, 0, 0, 15, 15, 0, 0, 0);
        #12;
        chk("rst_M_icode", bus.M_icode, 64'h1);
        chk("rst_M_dstE", bus.M_dstE, 64'hF);
        chk("rst_M_dstM", bus.M_dstM, 64'hF);
        chk("rst_M_valE", bus.M_valE, 64'h0);
        chk("rst_je_Cnd", bus.e_Cnd, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 6, 1, 0, 5, 5, 3, 15, 0, 0, 0);
        step();
        drive(1, 7, 4, 0, 0, 0, 15, 15, 0, 0, 0);
        #1 chk("jne_after_zero", bus.e_Cnd, 64'h0);
        step();
        drive(1, 7, 3, 0, 0, 0, 15, 15, 0, 0, 0);
        step();
        drive(1, 6, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2, 15, 0, 0, 0);
        #1 chk("add_ovf_valE", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        drive(1, 7, 6, 0, 0, 0, 15, 15, 0, 0, 0);
        #1 chk("jg_sf_of_set", bus.e_Cnd, 64'h1);
        step();
        drive(1, 6, 3, 0, 3, 3, 2, 15, 1, 0, 0);
        step();
        drive(1, 7, 3, 0, 0, 0, 15, 15, 0, 0, 0);
        #1 chk("je_cc_blocked", bus.e_Cnd, 64'h0);
        step();
        drive(1, 2, 2, 0, 64'h55, 0, 3, 15, 0, 0, 0);
        #1 chk("cmovl_dstE", bus.e_dstE, 64'hF);
        step();
        drive(1, 10, 0, 0, 7, 64'h100, 4, 15, 0, 0, 0);
        step();
        chk("push_valE", bus.M_valE, 64'hF8);
        chk("push_dstE", bus.M_dstE, 64'h4);
        drive(1, 6, 0, 0, 1, 1, 5, 15, 0, 1, 0);
        step();
        chk("stall_hold", bus.M_valE, 64'hF8);
        drive(1, 6, 0, 0, 1, 1, 5, 15, 0, 1, 1);
        step();
        chk("bubble_icode", bus.M_icode, 64'h1);
        chk("bubble_dstE", bus.M_dstE, 64'hF);
        drive(1, 6, 1, 0, 9, 2, 6, 15, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_icode", bus.M_icode, 64'h1);
        chk("async_rst_valE", bus.M_valE, 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 6, i, 0, 64'(i + 1), 64'd40, 1, 15, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 7, 0, 64'h40, 0, 0, 15, 15, 0, 0, 0);
            step();
        end
`ifdef EXEC_PERF_CNT_EN
        chk("perf_opq_3", perf_opq_cnt, 64'd3);
        chk("perf_jt_2", perf_jtaken_cnt, 64'd2);
`endif
        for (int i = 0; i < 400; i++) begin
            ic = $urandom_range(11);
            drive(($urandom_range(9) == 0) ? $urandom_range(4, 2) : 1, ic,
                  (ic == 6) ? (($urandom_range(7) == 0) ? $urandom_range(15, 4) : $urandom_range(3)) :
                  (ic == 2 || ic == 7) ? $urandom_range(7) : $urandom_range(15),
                  rnd64(), rnd64(), rnd64(), $urandom_range(15), $urandom_range(15),
                  $urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(7) == 0);
            step();
        end
        repeat (5) if (q.size() > 0) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
